// File: rtl/regbank_mp_pkg.sv
// Shared types and helpers for the multi-port register bank.
package regbank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 16;
  localparam int DEF_NRD    = 2;
  localparam int PC_IDX     = DEF_NREGS - 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    FWD_MEM = 2'd0,
    FWD_WR  = 2'd1,
    FWD_PC  = 2'd2
  } fwd_sel_t;

  // Source of a register's post-edge value: writeback beats PC load beats array.
  function automatic fwd_sel_t fwd_sel(input logic wr_hit, input logic pc_load, input logic is_pc);
    if (wr_hit)
      return FWD_WR;
    else if (pc_load && is_pc)
      return FWD_PC;
    else
      return FWD_MEM;
  endfunction

endpackage

// File: rtl/regbank_mp_if.sv
// Decoder/fetch/writeback bus into the register bank.
interface regbank_mp_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int NRD    = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0]        rdReqIn;
  logic [NRD*AW-1:0]     rdAddrIn;
  logic [NRD-1:0]        rdAckOut;
  logic [NRD*DATA_W-1:0] rdDataOut;
  logic                  rsvValidIn;
  logic [AW-1:0]         rsvAddrIn;
  logic                  wrEnIn;
  logic [AW-1:0]         wrAddrIn;
  logic [DATA_W-1:0]     wrDataIn;
  logic                  pcLoadIn;
  logic [DATA_W-1:0]     pcIn;
  logic [DATA_W-1:0]     pcOut;
  logic [NREGS-1:0]      busyOut;

  modport master (
    output rdReqIn, rdAddrIn, rsvValidIn, rsvAddrIn, wrEnIn, wrAddrIn, wrDataIn, pcLoadIn, pcIn,
    input  rdAckOut, rdDataOut, pcOut, busyOut
  );

  modport slave (
    input  rdReqIn, rdAddrIn, rsvValidIn, rsvAddrIn, wrEnIn, wrAddrIn, wrDataIn, pcLoadIn, pcIn,
    output rdAckOut, rdDataOut, pcOut, busyOut
  );
endinterface

// File: rtl/regbank_mp_rdport.sv
// One toggle-handshake read port: captures an address, stalls on busy, forwards same-cycle updates.
//   state | meaning
//   IDLE  | waiting for rdReqIn to differ from the last-seen request
//   WAIT  | address captured; ack once the register is free or released this cycle
module regbank_rdport
  import regbank_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  NREGS  = DEF_NREGS,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_pc_load,
  input  logic [DATA_W-1:0] i_pc_data,
  input  logic [DATA_W-1:0] i_mem_val,
  input  logic              i_in_rng,
  input  logic              i_busy,
  input  logic              i_busy_next,
  output logic [AW-1:0]     o_addr,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_data
);

  localparam logic [AW-1:0] PC_A = AW'(NREGS - 1);

  rd_state_t         r_state;
  logic              r_seen;
  logic [AW-1:0]     r_addr;
  logic              r_ack;
  logic [DATA_W-1:0] r_data;

  logic              w_wr_hit;
  logic              w_ready;
  logic [DATA_W-1:0] w_fwd;

  assign w_wr_hit = i_wr_en && (i_wr_addr == r_addr);
  // A write that is not re-reserved in the same cycle releases a stalled reader.
  assign w_ready  = !i_in_rng || !i_busy || (w_wr_hit && !i_busy_next);

  always_comb begin
    w_fwd = i_mem_val;
    case (fwd_sel(w_wr_hit, i_pc_load, r_addr == PC_A))
      FWD_WR:  w_fwd = i_wr_data;
      FWD_PC:  w_fwd = i_pc_data;
      default: w_fwd = i_mem_val;
    endcase
    if (!i_in_rng)
      w_fwd = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_seen  <= 1'b0;
      r_addr  <= '0;
      r_ack   <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req != r_seen) begin
            r_seen  <= i_req;
            r_addr  <= i_addr;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_ready) begin
            r_ack   <= i_req;
            r_data  <= w_fwd;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_addr = r_addr;
  assign o_ack  = r_ack;
  assign o_data = r_data;

endmodule

// File: rtl/regbank_mp.sv
// Register bank with PC, busy scoreboard, one writeback port and NRD toggle-handshake read ports.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  NREGS  = DEF_NREGS,
  parameter int  NRD    = DEF_NRD,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic     clk,
  input  logic     rst,
  regbank_mp_if.slave bus
);

  localparam int            PCI  = NREGS - 1;
  localparam logic [AW-1:0] PC_A = AW'(NREGS - 1);

  logic [DATA_W-1:0]     r_mem [NREGS];
  logic [NREGS-1:0]      r_busy;
  logic [DATA_W-1:0]     r_pc_out;

  logic                  w_wr_ok;
  logic                  w_rsv_ok;
  logic                  w_pc_wr;
  logic [NREGS-1:0]      w_busy_next;
  logic [NRD-1:0]        w_ack;
  logic [NRD*DATA_W-1:0] w_rdata;

  assign w_wr_ok  = bus.wrEnIn && (32'(bus.wrAddrIn) < NREGS);
  assign w_rsv_ok = bus.rsvValidIn && (32'(bus.rsvAddrIn) < NREGS);
  assign w_pc_wr  = w_wr_ok && (bus.wrAddrIn == PC_A);

  // Reserve is applied after the clear so a same-cycle reservation wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_ok)
      w_busy_next[bus.wrAddrIn] = 1'b0;
    if (w_rsv_ok)
      w_busy_next[bus.rsvAddrIn] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++)
        r_mem[k] <= '0;
      r_pc_out <= '0;
    end else begin
      if (w_wr_ok)
        r_mem[bus.wrAddrIn] <= bus.wrDataIn;
      if (bus.pcLoadIn && !w_pc_wr)
        r_mem[PCI] <= bus.pcIn;
      r_pc_out <= r_mem[PCI];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_busy <= '0;
    else
      r_busy <= w_busy_next;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]     w_addr;
    logic              w_rng;
    logic              w_busy;
    logic              w_busy_nx;
    logic [DATA_W-1:0] w_mem_val;

    assign w_rng     = 32'(w_addr) < NREGS;
    assign w_busy    = w_rng ? r_busy[w_addr] : 1'b0;
    assign w_busy_nx = w_rng ? w_busy_next[w_addr] : 1'b0;
    assign w_mem_val = w_rng ? r_mem[w_addr] : '0;

    regbank_rdport #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
    ) u_rdport (
      .clk         (clk),
      .rst         (rst),
      .i_req       (bus.rdReqIn[g]),
      .i_addr      (bus.rdAddrIn[g*AW +: AW]),
      .i_wr_en     (w_wr_ok),
      .i_wr_addr   (bus.wrAddrIn),
      .i_wr_data   (bus.wrDataIn),
      .i_pc_load   (bus.pcLoadIn),
      .i_pc_data   (bus.pcIn),
      .i_mem_val   (w_mem_val),
      .i_in_rng    (w_rng),
      .i_busy      (w_busy),
      .i_busy_next (w_busy_nx),
      .o_addr      (w_addr),
      .o_ack       (w_ack[g]),
      .o_data      (w_rdata[g*DATA_W +: DATA_W])
    );
  end

  assign bus.rdAckOut  = w_ack;
  assign bus.rdDataOut = w_rdata;
  assign bus.pcOut     = r_pc_out;
  assign bus.busyOut   = r_busy;

endmodule

// File: tb/tb_regbank_mp.sv
// Directed and randomized checks of regbank_mp against a register/scoreboard reference model.
module tb_regbank_mp;
  import regbank_pkg::*;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int NP = 2;
  localparam int AW = 4;
  localparam int PC = NR - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regbank_mp_if #(.DATA_W(DW), .NREGS(NR), .NRD(NP)) bus ();
  regbank_mp #(.DATA_W(DW), .NREGS(NR), .NRD(NP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] m_mem  [NR];
  logic          m_busy [NR];
  logic [DW-1:0] m_pc_out;
  int            m_st   [NP];   // 0 idle, 1 request pending capture, 2 waiting
  int            m_addr [NP];
  logic          m_req  [NP];
  logic          m_ack  [NP];
  logic [DW-1:0] m_data [NP];

  // per-cycle stimulus
  logic          s_wr  = 1'b0;
  int            s_wa  = 0;
  logic [DW-1:0] s_wd  = '0;
  logic          s_rsv = 1'b0;
  int            s_ra  = 0;
  logic          s_pcl = 1'b0;
  logic [DW-1:0] s_pc  = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) begin
      m_mem[k]  = '0;
      m_busy[k] = 1'b0;
    end
    m_pc_out = '0;
    for (int p = 0; p < NP; p++) begin
      m_st[p] = 0; m_addr[p] = 0; m_req[p] = 1'b0; m_ack[p] = 1'b0; m_data[p] = '0;
    end
  endtask

  task automatic drive();
    bus.wrEnIn     = s_wr;
    bus.wrAddrIn   = AW'(s_wa);
    bus.wrDataIn   = s_wd;
    bus.rsvValidIn = s_rsv;
    bus.rsvAddrIn  = AW'(s_ra);
    bus.pcLoadIn   = s_pcl;
    bus.pcIn       = s_pc;
    for (int p = 0; p < NP; p++) begin
      bus.rdReqIn[p]            = m_req[p];
      bus.rdAddrIn[p*AW +: AW]  = AW'(m_addr[p]);
    end
  endtask

  task automatic req(input int p, input int a);
    if (m_st[p] == 0) begin
      m_addr[p] = a;
      m_req[p]  = ~m_req[p];
      m_st[p]   = 1;
    end
  endtask

  function automatic logic [DW-1:0] busy_vec();
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) v[k] = m_busy[k];
    return v;
  endfunction

  task automatic cycle();
    logic [DW-1:0] nmem  [NR];
    logic          nbusy [NR];
    logic          rel;
    drive();
    nmem  = m_mem;
    nbusy = m_busy;
    if (s_wr) begin
      nmem[s_wa]  = s_wd;
      nbusy[s_wa] = 1'b0;
    end
    if (s_pcl && !(s_wr && s_wa == PC)) nmem[PC] = s_pc;
    if (s_rsv) nbusy[s_ra] = 1'b1;
    for (int p = 0; p < NP; p++) begin
      if (m_st[p] == 2) begin
        rel = !m_busy[m_addr[p]] ||
              (s_wr && s_wa == m_addr[p] && !(s_rsv && s_ra == m_addr[p]));
        if (rel) begin
          m_ack[p]  = m_req[p];
          m_data[p] = nmem[m_addr[p]];
          m_st[p]   = 0;
        end
      end else if (m_st[p] == 1) begin
        m_st[p] = 2;
      end
    end
    m_pc_out = m_mem[PC];
    m_mem    = nmem;
    m_busy   = nbusy;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("ack%0d", p), DW'(bus.rdAckOut[p]), DW'(m_ack[p]));
      chk($sformatf("data%0d", p), bus.rdDataOut[p*DW +: DW], m_data[p]);
    end
    chk("busy", DW'(bus.busyOut), busy_vec());
    chk("pc", bus.pcOut, m_pc_out);
    s_wr = 1'b0; s_rsv = 1'b0; s_pcl = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    drive();
    #12;
    chk("rst_ack", DW'(bus.rdAckOut), '0);
    chk("rst_data", bus.rdDataOut[DW-1:0], '0);
    chk("rst_busy", DW'(bus.busyOut), '0);
    chk("rst_pc", bus.pcOut, '0);
    @(negedge clk);
    rst = 1'b0;

    // basic write then read with minimum latency
    s_wr = 1'b1; s_wa = 3; s_wd = 32'hDEADBEEF;
    cycle();
    req(0, 3);
    cycle();
    cycle();
    chk("t1_ack", DW'(bus.rdAckOut[0]), 32'd1);
    chk("t1_data", bus.rdDataOut[DW-1:0], 32'hDEADBEEF);

    // scoreboard stall released by writeback
    s_rsv = 1'b1; s_ra = 5;
    cycle();
    req(1, 5);
    cycle();
    repeat (4) cycle();
    chk("t2_stall", DW'(bus.rdAckOut[1]), 32'd0);
    s_wr = 1'b1; s_wa = 5; s_wd = 32'h1234;
    cycle();
    chk("t2_ack", DW'(bus.rdAckOut[1]), 32'd1);
    chk("t2_data", bus.rdDataOut[DW +: DW], 32'h1234);
    chk("t2_busy", DW'(bus.busyOut[5]), 32'd0);

    // write forwarding into a waiting read
    req(0, 7);
    cycle();
    s_wr = 1'b1; s_wa = 7; s_wd = 32'hA5A5A5A5;
    cycle();
    chk("t3_fwd", bus.rdDataOut[DW-1:0], 32'hA5A5A5A5);

    // PC priority, then plain load, then forwarded PC read
    s_pcl = 1'b1; s_pc = 32'h100; s_wr = 1'b1; s_wa = PC; s_wd = 32'h200;
    cycle();
    cycle();
    chk("t4_pc_wb", bus.pcOut, 32'h200);
    s_pcl = 1'b1; s_pc = 32'h204;
    cycle();
    cycle();
    chk("t4_pc_ld", bus.pcOut, 32'h204);
    req(1, PC);
    cycle();
    s_pcl = 1'b1; s_pc = 32'h300;
    cycle();
    chk("t4_pc_rd", bus.rdDataOut[DW +: DW], 32'h300);

    // reserve and write on the same register in one cycle
    s_rsv = 1'b1; s_ra = 2; s_wr = 1'b1; s_wa = 2; s_wd = 32'd9;
    cycle();
    chk("t5_busy", DW'(bus.busyOut[2]), 32'd1);
    req(0, 2);
    repeat (3) cycle();
    chk("t5_stall", DW'(bus.rdAckOut[0]), 32'd0);
    s_wr = 1'b1; s_wa = 2; s_wd = 32'd11;
    cycle();
    chk("t5_ack", DW'(bus.rdAckOut[0]), 32'd1);
    chk("t5_data", bus.rdDataOut[DW-1:0], 32'd11);
    chk("t5_clr", DW'(bus.busyOut[2]), 32'd0);

    // async reset while a port is stalled
    s_rsv = 1'b1; s_ra = 4;
    cycle();
    req(0, 4);
    cycle();
    cycle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_ack", DW'(bus.rdAckOut), '0);
    chk("t6_busy", DW'(bus.busyOut), '0);
    chk("t6_pc", bus.pcOut, '0);
    chk("t6_data0", bus.rdDataOut[DW-1:0], '0);
    chk("t6_data1", bus.rdDataOut[DW +: DW], '0);
    model_reset();
    drive();
    @(negedge clk);
    rst = 1'b0;
    req(0, 3);
    req(1, PC);
    cycle();
    cycle();
    chk("t6_r3", bus.rdDataOut[DW-1:0], '0);
    chk("t6_pc_rd", bus.rdDataOut[DW +: DW], '0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++)
        if (m_st[p] == 0 && $urandom_range(2) == 0) req(p, $urandom_range(NR - 1));
      if ($urandom_range(2) == 0) begin
        s_wr = 1'b1; s_wa = $urandom_range(NR - 1); s_wd = $urandom;
      end
      if ($urandom_range(4) == 0) begin
        s_rsv = 1'b1; s_ra = $urandom_range(NR - 1);
      end
      if ($urandom_range(3) == 0) begin
        s_pcl = 1'b1; s_pc = $urandom;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
